// File: rtl/output_uart.sv
// output_uart: buffers 16-bit words in a small FIFO and sends each one on an
// 8N1 serial line as two back-to-back frames, low byte first, with one idle
// cycle between words.
module output_uart #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] output_val,
    input  logic        output_enable,
    output logic        uart_tx,
    output logic        fifo_full,
    output logic        overflow,
    output logic        tx_busy
);

    // Pointer width; FIFO_DEPTH is a power of two so pointers wrap for free.
    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    // Occupancy needs one extra bit to represent "exactly full".
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] COUNT_ZERO = CW'(0);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ZERO   = AW'(0);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    // Bit-period counter counts down from this value to zero.
    localparam logic [15:0]   BIT_LAST_C = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    logic [15:0]   fifo_mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          fifo_full_r;
    logic          overflow_r;

    logic          full_s;
    logic          pop_s;
    logic          push_s;
    logic          drop_s;
    logic [CW-1:0] count_next_s;
    logic [15:0]   head_word_s;

    // ------------------------------------------------------------------
    // Serializer state
    // ------------------------------------------------------------------
    tx_state_t     state_r;
    logic [15:0]   bit_cnt_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    shift_byte_r;
    logic [7:0]    hi_byte_r;
    logic          hi_phase_r;
    logic          uart_tx_r;
    logic          tx_busy_r;

    // Push/pop decisions: the serializer pops whenever it idles with data
    // waiting, and a push into a full FIFO is only accepted if that pop
    // frees a slot in the same cycle.
    always_comb begin
        full_s      = (count_r == DEPTH_C);
        head_word_s = fifo_mem_r[rd_ptr_r];
        if ((state_r == ST_IDLE) && (count_r != COUNT_ZERO)) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        push_s = output_enable & (~full_s | pop_s);
        drop_s = output_enable & full_s & ~pop_s;
    end

    // Occupancy after this edge, shared by fifo_full and tx_busy so both
    // flags describe the post-edge FIFO contents.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + COUNT_ONE;
            2'b01:   count_next_s = count_r - COUNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // FIFO storage write; contents need no reset because pointers do.
    always_ff @(posedge clk) begin
        if (!reset && push_s) begin
            fifo_mem_r[wr_ptr_r] <= output_val;
        end
    end

    // FIFO pointers, occupancy and the full/overflow flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            count_r     <= COUNT_ZERO;
            fifo_full_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r     <= count_next_s;
            fifo_full_r <= (count_next_s == DEPTH_C);
            // Sticky until reset: once a word is lost the host must know.
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Serializer FSM: walks IDLE -> START -> DATA -> STOP for the low byte,
    // loops straight back to START for the high byte, then rests in IDLE
    // for exactly one cycle before the next word. The bit counter reloads
    // at every state change and every data-bit boundary so bit periods
    // never accumulate error.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            bit_cnt_r    <= 16'd0;
            bit_idx_r    <= 3'd0;
            shift_byte_r <= 8'd0;
            hi_byte_r    <= 8'd0;
            hi_phase_r   <= 1'b0;
            uart_tx_r    <= 1'b1;
            tx_busy_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        shift_byte_r <= head_word_s[7:0];
                        hi_byte_r    <= head_word_s[15:8];
                        hi_phase_r   <= 1'b0;
                        bit_cnt_r    <= BIT_LAST_C;
                        bit_idx_r    <= 3'd0;
                        uart_tx_r    <= 1'b0;
                        tx_busy_r    <= 1'b1;
                        state_r      <= ST_START;
                    end else begin
                        bit_cnt_r    <= 16'd0;
                        uart_tx_r    <= 1'b1;
                        tx_busy_r    <= (count_next_s != COUNT_ZERO);
                        state_r      <= ST_IDLE;
                    end
                end

                ST_START: begin
                    tx_busy_r <= 1'b1;
                    if (bit_cnt_r == 16'd0) begin
                        // First data bit goes out as the start bit ends.
                        bit_cnt_r <= BIT_LAST_C;
                        bit_idx_r <= 3'd0;
                        uart_tx_r <= shift_byte_r[0];
                        state_r   <= ST_DATA;
                    end else begin
                        bit_cnt_r <= bit_cnt_r - 16'd1;
                        uart_tx_r <= 1'b0;
                        state_r   <= ST_START;
                    end
                end

                ST_DATA: begin
                    tx_busy_r <= 1'b1;
                    if (bit_cnt_r == 16'd0) begin
                        bit_cnt_r <= BIT_LAST_C;
                        if (bit_idx_r == 3'd7) begin
                            uart_tx_r <= 1'b1;
                            state_r   <= ST_STOP;
                        end else begin
                            // LSB-first: shift the next bit into position 0.
                            bit_idx_r    <= bit_idx_r + 3'd1;
                            shift_byte_r <= {1'b0, shift_byte_r[7:1]};
                            uart_tx_r    <= shift_byte_r[1];
                            state_r      <= ST_DATA;
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r - 16'd1;
                        uart_tx_r <= shift_byte_r[0];
                        state_r   <= ST_DATA;
                    end
                end

                ST_STOP: begin
                    if (bit_cnt_r == 16'd0) begin
                        if (!hi_phase_r) begin
                            // High byte follows with no gap.
                            shift_byte_r <= hi_byte_r;
                            hi_phase_r   <= 1'b1;
                            bit_cnt_r    <= BIT_LAST_C;
                            bit_idx_r    <= 3'd0;
                            uart_tx_r    <= 1'b0;
                            tx_busy_r    <= 1'b1;
                            state_r      <= ST_START;
                        end else begin
                            hi_phase_r   <= 1'b0;
                            bit_cnt_r    <= 16'd0;
                            uart_tx_r    <= 1'b1;
                            tx_busy_r    <= (count_next_s != COUNT_ZERO);
                            state_r      <= ST_IDLE;
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r - 16'd1;
                        uart_tx_r <= 1'b1;
                        tx_busy_r <= 1'b1;
                        state_r   <= ST_STOP;
                    end
                end

                default: begin
                    bit_cnt_r <= 16'd0;
                    uart_tx_r <= 1'b1;
                    tx_busy_r <= (count_next_s != COUNT_ZERO);
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign uart_tx   = uart_tx_r;
    assign fifo_full = fifo_full_r;
    assign overflow  = overflow_r;
    assign tx_busy   = tx_busy_r;

endmodule

// File: tb/tb_output_uart.sv
// Self-checking bench for output_uart (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// A word-level model (queue + position within a 20-bit-period word) predicts
// every output each cycle; an independent line receiver decodes uart_tx.
module tb_output_uart;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] output_val;
    logic        output_enable;
    logic        uart_tx;
    logic        fifo_full;
    logic        overflow;
    logic        tx_busy;

    always #5 clk = ~clk;

    output_uart #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .output_val    (output_val),
        .output_enable (output_enable),
        .uart_tx       (uart_tx),
        .fifo_full     (fifo_full),
        .overflow      (overflow),
        .tx_busy       (tx_busy)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [15:0] mq[$];
    bit          m_active = 1'b0;
    int          m_t      = 0;
    logic [15:0] m_word   = 16'h0;
    bit          m_ovf    = 1'b0;

    // Receiver state
    logic [7:0]  rx_bytes[$];
    int          rx_phase = -1;
    logic [7:0]  rx_sh    = 8'h0;

    logic [15:0] wl[$];

    // Expected line level at position m_t of the current word.
    function automatic logic exp_tx();
        int fr;
        int b;
        logic [7:0] by;
        if (!m_active) return 1'b1;
        fr = m_t / (10 * CPB);
        b  = (m_t % (10 * CPB)) / CPB;
        by = (fr == 0) ? m_word[7:0] : m_word[15:8];
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return by[b-1];
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance model, apply one clock edge, compare, run receiver.
    task automatic tick();
        bit pop;
        bit acc;
        bit was_reset;
        was_reset = reset;
        pop = !m_active && (mq.size() > 0);
        if (reset) begin
            mq.delete();
            m_active = 1'b0;
            m_t      = 0;
            m_ovf    = 1'b0;
        end else begin
            acc = output_enable && ((mq.size() < DEPTH) || pop);
            if (output_enable && !acc) m_ovf = 1'b1;
            if (m_active) begin
                m_t++;
                if (m_t == 20 * CPB) m_active = 1'b0;
            end else if (pop) begin
                m_word   = mq.pop_front();
                m_active = 1'b1;
                m_t      = 0;
            end
            if (acc) mq.push_back(output_val);
        end
        @(posedge clk);
        #1;
        check("cycle", {12'h0, uart_tx, fifo_full, overflow, tx_busy},
              {12'h0, exp_tx(), (mq.size() == DEPTH), m_ovf, (m_active || (mq.size() > 0))});
        if (was_reset) begin
            rx_phase = -1;
        end else if (rx_phase < 0) begin
            if (uart_tx == 1'b0) rx_phase = 0;
        end else begin
            rx_phase++;
            if ((rx_phase % CPB == CPB / 2) && (rx_phase >= CPB) && (rx_phase < 9 * CPB))
                rx_sh = {uart_tx, rx_sh[7:1]};
            if (rx_phase == 9 * CPB + CPB / 2) begin
                check("stop_bit", {15'h0, uart_tx}, 16'h0001);
                rx_bytes.push_back(rx_sh);
                rx_phase = -1;
            end
        end
    endtask

    task automatic push(input logic [15:0] w);
        output_enable = 1'b1;
        output_val    = w;
        tick();
        output_enable = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((m_active || (mq.size() > 0)) && n < 5000) begin
            tick();
            n++;
        end
        idle(2);
        check("drain_busy", {15'h0, tx_busy}, 16'h0000);
    endtask

    task automatic check_words(input string tag, input logic [15:0] words[$]);
        check({tag, "_count"}, 16'(rx_bytes.size()), 16'(2 * words.size()));
        for (int i = 0; i < words.size(); i++) begin
            if (2 * i + 1 < rx_bytes.size()) begin
                check({tag, "_lo"}, {8'h0, rx_bytes[2*i]},   {8'h0, words[i][7:0]});
                check({tag, "_hi"}, {8'h0, rx_bytes[2*i+1]}, {8'h0, words[i][15:8]});
            end
        end
    endtask

    initial begin
        int n;
        reset         = 1'b1;
        output_enable = 1'b0;
        output_val    = 16'h0;

        // Reset state
        idle(2);
        check("reset_flags", {12'h0, uart_tx, fifo_full, overflow, tx_busy}, 16'h0008);
        reset = 1'b0;
        idle(3);

        // Single word 0x4142, busy for 81 cycles after the push edge
        rx_bytes.delete();
        push(16'h4142);
        n = 0;
        while (tx_busy && n < 200) begin
            tick();
            n++;
        end
        check("busy_len", 16'(n), 16'd81);
        wl = {16'h4142};
        check_words("w4142", wl);
        idle(3);

        // Three consecutive pushes
        rx_bytes.delete();
        push(16'h0001);
        push(16'h0002);
        push(16'h0003);
        drain();
        wl = {16'h0001, 16'h0002, 16'h0003};
        check_words("three", wl);
        check("three_ovf", {15'h0, overflow}, 16'h0000);

        // Six consecutive pushes: sixth dropped
        rx_bytes.delete();
        wl.delete();
        for (int i = 0; i < 6; i++) begin
            wl.push_back(16'($urandom));
            push(wl[i]);
        end
        check("six_ovf", {15'h0, overflow}, 16'h0001);
        check("six_full", {15'h0, fifo_full}, 16'h0001);
        void'(wl.pop_back());
        drain();
        check_words("six", wl);
        check("six_ovf_sticky", {15'h0, overflow}, 16'h0001);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("ovf_cleared", {15'h0, overflow}, 16'h0000);

        // Push into a full FIFO on the pop cycle
        rx_bytes.delete();
        wl.delete();
        for (int i = 0; i < 5; i++) begin
            wl.push_back(16'($urandom));
            push(wl[i]);
        end
        check("fill_full", {15'h0, fifo_full}, 16'h0001);
        n = 0;
        while (m_active && n < 500) begin
            tick();
            n++;
        end
        wl.push_back(16'hA55A);
        push(16'hA55A);
        check("popcycle_ovf", {15'h0, overflow}, 16'h0000);
        check("popcycle_full", {15'h0, fifo_full}, 16'h0001);
        drain();
        check_words("popcycle", wl);

        // Reset in the middle of the high-byte data bits, with a push
        push(16'h1234);
        n = 0;
        while (m_t < 60 && n < 500) begin
            tick();
            n++;
        end
        reset         = 1'b1;
        output_enable = 1'b1;
        output_val    = 16'hBEEF;
        tick();
        reset         = 1'b0;
        output_enable = 1'b0;
        check("midreset_flags", {12'h0, uart_tx, fifo_full, overflow, tx_busy}, 16'h0008);
        idle(2);
        rx_bytes.delete();
        push(16'h00FF);
        drain();
        wl = {16'h00FF};
        check_words("after_reset", wl);

        // Stream 20 random words with random gaps
        rx_bytes.delete();
        wl.delete();
        for (int k = 0; k < 20; k++) begin
            idle($urandom_range(0, 50));
            n = 0;
            while (mq.size() == DEPTH && n < 1000) begin
                tick();
                n++;
            end
            wl.push_back(16'($urandom));
            push(wl[k]);
        end
        drain();
        check_words("stream", wl);
        check("stream_ovf", {15'h0, overflow}, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
